poly_note_synth: RTL
====================

Name: poly_note_synth

Overview:
- Parametrised successor to the single-voice note-to-audio path: synthesises NUM_VOICES simultaneous notes from one shared sine wavetable using per-voice phase accumulators, then mixes them into one signed audio sample per sample_tick.
- Sits between the score/keyboard note sources and the audio codec interface.
- Owns the score note-address counter and its done flags.
- Adds polyphony, arbitrary octave shift, a rest code and sample-rate strobing, none of which the previous block has.

Parameters:
NUM_VOICES, 4, simultaneous voices (power of 2, 1..8)
SAMPLE_W, 24, signed audio sample width
PHASE_W, 24, phase accumulator width
WT_ADR_W, 8, wavetable address bits (table depth 2**WT_ADR_W)
NUM_OCT, 4, octaves supported; octave index 0 = C4
ADR_W, 6, score note-address width

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high; clock clk
init  in  1  clears score address and all voice phases
play_en  in  1  enables score address advance
sample_tick  in  1  one-cycle strobe at the audio sample rate (48 kHz)
finish_len  in  1  one-cycle pulse marking the end of the current note length
note  in  5*NUM_VOICES  per-voice note code; 0..12*NUM_OCT-1 plays that note; 31 = rest
oct_shift  in  2  octave offset added to every voice
save_len  in  ADR_W  number of notes in the saved score
score_adr  out  ADR_W  current score note address
audio  out  SAMPLE_W  mixed signed sample
audio_valid  out  1  one-cycle pulse when audio updates
done_rand  out  1  asserted while score_adr == 2**ADR_W-1
done_save  out  1  asserted while score_adr >= save_len
overrun  out  1  sticky; set when a sample_tick is dropped

Behaviour:
- Reset values: score_adr=0, audio=0, audio_valid=0, overrun=0, all phases=0, FSM in IDLE.
- init (when not in reset): same effect as reset except overrun is kept. init has priority over finish_len in the same cycle.
- Score counter: score_adr increments by 1 on a finish_len pulse while play_en=1. It wraps from 2**ADR_W-1 to 0.
- Pitch, per voice:
  - semitone = note%12.
  - eff_oct = note/12 + oct_shift, clamped to NUM_OCT-1.
  - inc = BASE_INC[semitone] >> (NUM_OCT-1-eff_oct).
  - Any code above 12*NUM_OCT-1 other than 31 is treated as rest.
- Rest: the voice contributes 0 and its phase is forced to 0, so the next note starts at phase 0.
- FSM states and sequence:
  - IDLE: sample_tick seen at cycle t moves to ISSUE.
  - ISSUE: runs cycles t+1..t+NUM_VOICES. In cycle t+k, voice k-1 drives the ROM address with phase[PHASE_W-1 -: WT_ADR_W], and phase <= phase+inc (modulo 2**PHASE_W).
  - ROM: 1-cycle read latency. Data is accumulated in cycles t+2..t+NUM_VOICES+1.
  - DRAIN: covers the final ROM read at t+NUM_VOICES+1.
  - OUT: at t+NUM_VOICES+2, audio <= acc >>> log2(NUM_VOICES) (arithmetic shift), audio_valid=1 for 1 cycle, then back to IDLE.
- Accumulator: SAMPLE_W+log2(NUM_VOICES) bits, signed, cleared at the start of each ISSUE. It cannot overflow.
- Note sampling: note and oct_shift are sampled at each voice's ISSUE cycle. Changes mid-frame affect only voices not yet issued.
- sample_tick outside IDLE: the tick is dropped, overrun is set, and the frame in progress continues unaffected.
- reset mid-frame: aborts the frame and audio_valid is not pulsed.

Decomposition:
- Package poly_synth_pkg holds:
  - BASE_INC[0:11], the top-octave phase increments at 48 kHz for PHASE_W=24 (C7..B7; e.g. A7 = 1230329).
  - REST_CODE = 31.
  - The FSM state enum {IDLE, ISSUE, DRAIN, OUT}.
- One sub-module, sine_rom: synchronous ROM, 2**WT_ADR_W × SAMPLE_W signed full-cycle sine, 1-cycle latency, address 0 = 0.

Test Plan:
- Reset then one tick, all voices rest: audio_valid at t+6 (NUM_VOICES=4), audio=0, all phases 0.
- Voice0 note=9 (A4), oct_shift=0, others rest: inc=153791. After 2 ticks phase0=307582; the second frame's ROM index is 153791>>16 = 2, and audio = sine_rom[2]>>>2.
- Voice0 note=9, oct_shift=3: inc=1230329. Same note with oct_shift=3 and note=21 clamps to octave 3 and gives the same inc.
- finish_len ×63 with play_en=1 → score_adr=63, done_rand=1. With save_len=43, done_save rises at the 43rd pulse. init together with finish_len → score_adr=0.
- sample_tick again 3 cycles after a tick → overrun=1 and only one audio_valid pulse. overrun stays 1 after init and clears only on reset.
- reset at t+3 mid-frame → no audio_valid, audio=0, phases=0. The next tick produces a normal frame.

Source files
------------

// File: rtl/poly_synth_pkg.sv
// Shared definitions for the polyphonic note synthesiser.
//   BASE_INC  : top-octave (C7..B7) phase increments for a 24-bit phase
//               accumulator stepped at 48 kHz, rounded to nearest.
//   REST_CODE : note code that silences a voice.
//   state_t   : frame sequencer states.
package poly_synth_pkg;

  localparam int REST_CODE    = 31;
  localparam int BASE_PHASE_W = 24;

  localparam int unsigned BASE_INC [12] = '{
    731558,  775059,  821146,  869974,  921705,  976513,
    1034579, 1096099, 1161276, 1230329, 1303489, 1380998
  };

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

endpackage

// File: rtl/poly_note_synth_sine_rom.sv
// Synchronous full-cycle sine wavetable, 2**WT_ADR_W entries of signed
// SAMPLE_W samples with peak 2**(SAMPLE_W-1)-1; entry 0 is 0.
//   clk  : clock
//   adr  : table address
//   data : sample at adr, one cycle after adr is presented
module sine_rom #(
  parameter int SAMPLE_W = 24,
  parameter int WT_ADR_W = 8
) (
  input  logic                       clk,
  input  logic [WT_ADR_W-1:0]        adr,
  output logic signed [SAMPLE_W-1:0] data
);

  localparam int     DEPTH      = 2 ** WT_ADR_W;
  localparam longint TWO_PI_Q30 = 64'sd6746518852;

  // Elaboration-time sine: fold to the first quadrant, then an integer
  // Taylor series in Q30 (error far below one LSB of a 24-bit sample).
  function automatic logic signed [SAMPLE_W-1:0] sine_sample(input int idx);
    longint quarter, half, q, ang, x2, term, sum, amp, scaled;
    logic   neg;
    quarter = longint'(DEPTH / 4);
    half    = longint'(DEPTH / 2);
    if (longint'(idx) <= quarter) begin
      q = longint'(idx);  neg = 1'b0;
    end else if (longint'(idx) <= half) begin
      q = half - longint'(idx);  neg = 1'b0;
    end else if (longint'(idx) < 3 * quarter) begin
      q = longint'(idx) - half;  neg = 1'b1;
    end else begin
      q = longint'(DEPTH) - longint'(idx);  neg = 1'b1;
    end
    ang  = (q * TWO_PI_Q30) / longint'(DEPTH);
    x2   = (ang * ang) >>> 30;
    term = ang;
    sum  = ang;
    for (int k = 1; k <= 7; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    amp    = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
    scaled = (sum * amp + (64'sd1 <<< 29)) >>> 30;
    if (scaled > amp) scaled = amp;
    return SAMPLE_W'(neg ? -scaled : scaled);
  endfunction

  logic signed [SAMPLE_W-1:0] table_mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    localparam logic signed [SAMPLE_W-1:0] VAL = sine_sample(i);
    assign table_mem[i] = VAL;
  end

  always_ff @(posedge clk) begin
    data <= table_mem[adr];
  end

endmodule

// File: rtl/poly_note_synth.sv
// Polyphonic note synthesiser: NUM_VOICES phase accumulators share one sine
// wavetable, visited one voice per cycle after each sample_tick; the voice
// samples are summed and scaled down by NUM_VOICES into one audio sample.
// Also owns the score note-address counter and its done flags.
//   clk, reset     : clock, synchronous active-high reset
//   init           : clear score address, phases, audio and sequencer
//   play_en        : allow score address advance
//   sample_tick    : audio-rate strobe starting a frame
//   finish_len     : end-of-note pulse advancing score_adr
//   note           : 5-bit note code per voice (voice v at [5v +: 5])
//   oct_shift      : octave offset applied to every voice
//   save_len       : saved score length
//   score_adr      : current score note address
//   audio          : mixed signed sample, audio_valid pulses on update
//   done_rand      : score_adr at its maximum
//   done_save      : score_adr reached save_len
//   overrun        : sticky, a sample_tick arrived while a frame was busy
module poly_note_synth
  import poly_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 24,
  parameter int PHASE_W    = 24,
  parameter int WT_ADR_W   = 8,
  parameter int NUM_OCT    = 4,
  parameter int ADR_W      = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic                       play_en,
  input  logic                       sample_tick,
  input  logic                       finish_len,
  input  logic [5*NUM_VOICES-1:0]    note,
  input  logic [1:0]                 oct_shift,
  input  logic [ADR_W-1:0]           save_len,
  output logic [ADR_W-1:0]           score_adr,
  output logic signed [SAMPLE_W-1:0] audio,
  output logic                       audio_valid,
  output logic                       done_rand,
  output logic                       done_save,
  output logic                       overrun
);

  localparam int LOG_NV = $clog2(NUM_VOICES);
  localparam int VC_W   = (NUM_VOICES > 1) ? LOG_NV : 1;
  localparam int ACC_W  = SAMPLE_W + LOG_NV;

  function automatic logic is_rest(input logic [4:0] code);
    return (code == 5'(REST_CODE)) || (int'(code) >= 12 * NUM_OCT);
  endfunction

  function automatic logic [PHASE_W-1:0] voice_inc(input logic [4:0] code,
                                                   input logic [1:0] shift);
    int     semi, oct;
    longint base;
    semi = int'(code) % 12;
    oct  = int'(code) / 12 + int'(shift);
    if (oct > NUM_OCT - 1) oct = NUM_OCT - 1;
    base = (longint'(BASE_INC[semi]) <<< PHASE_W) >>> BASE_PHASE_W;
    base = base >>> (NUM_OCT - 1 - oct);
    return PHASE_W'(base);
  endfunction

  state_t                     state, state_next;
  logic [VC_W-1:0]            vcnt;
  logic [PHASE_W-1:0]         phase [NUM_VOICES];
  logic [4:0]                 cur_note;
  logic                       cur_rest;
  logic [PHASE_W-1:0]         cur_inc;
  logic                       last_voice;
  logic [WT_ADR_W-1:0]        rom_adr_p0;
  logic signed [SAMPLE_W-1:0] rom_data_p1;
  logic                       vld_p1;
  logic signed [ACC_W-1:0]    rom_ext_p1;
  logic signed [ACC_W-1:0]    acc, acc_next;

  // Stage p0: voice vcnt presents its phase to the wavetable.
  always_comb begin
    cur_note   = note[5*int'(vcnt) +: 5];
    cur_rest   = is_rest(cur_note);
    cur_inc    = voice_inc(cur_note, oct_shift);
    last_voice = (vcnt == VC_W'(NUM_VOICES - 1));
    rom_adr_p0 = '0;
    // A resting voice reads entry 0 (value 0) so it adds nothing to the mix.
    if (state == ISSUE && !cur_rest)
      rom_adr_p0 = phase[vcnt][PHASE_W-1 -: WT_ADR_W];
  end

  sine_rom #(
    .SAMPLE_W (SAMPLE_W),
    .WT_ADR_W (WT_ADR_W)
  ) u_rom (
    .clk  (clk),
    .adr  (rom_adr_p0),
    .data (rom_data_p1)
  );

  // Stage p1: wavetable output accumulated.
  always_comb begin
    rom_ext_p1 = '0;
    if (vld_p1) rom_ext_p1 = ACC_W'(rom_data_p1);
    acc_next = acc + rom_ext_p1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = ISSUE;
      ISSUE:   if (last_voice) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || init) state <= IDLE;
    else               state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      vcnt        <= '0;
      vld_p1      <= 1'b0;
      acc         <= '0;
      audio       <= '0;
      audio_valid <= 1'b0;
      score_adr   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
    end else begin
      vld_p1      <= (state == ISSUE);
      // Registered in DRAIN so the pulse and the new sample appear together
      // during OUT.
      audio_valid <= (state == DRAIN);
      if (state == IDLE && sample_tick) begin
        vcnt <= '0;
        acc  <= '0;
      end else if (state == ISSUE || state == DRAIN) begin
        acc <= acc_next;
      end
      if (state == ISSUE) begin
        vcnt        <= vcnt + 1'b1;
        phase[vcnt] <= cur_rest ? '0 : phase[vcnt] + cur_inc;
      end
      if (state == DRAIN) audio <= SAMPLE_W'(acc_next >>> LOG_NV);
      if (finish_len && play_en) score_adr <= score_adr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             overrun <= 1'b0;
    else if (sample_tick && state != IDLE) overrun <= 1'b1;
  end

  assign done_rand = (score_adr == '1);
  assign done_save = (score_adr >= save_len);

endmodule
